pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line written to memory.
REQ-002 Parameter V_VISIBLE, default 480, visible lines per frame written to memory.
REQ-003 Parameter H_LAST, default 799, last x_draw value of a scan line.
REQ-004 Parameter V_LAST, default 524, last y_draw value of a frame.
REQ-005 Parameter FIFO_DEPTH, default 8, pixel buffer entries (power of two).
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 CLK  in  1  clock; all state updates on rising edge.
REQ-008 RESET  in  1  synchronous, active-high reset.
REQ-009 calculating  in  1  input pixel valid, from the fractal calculator.
REQ-010 x_draw  in  10  pixel column of the current input.
REQ-011 y_draw  in  10  pixel row of the current input.
REQ-012 intensity  in  8  pixel intensity of the current input.
REQ-013 mem_addr  out  19  frame-buffer word address.
REQ-014 mem_data  out  8  frame-buffer write data.
REQ-015 mem_we  out  1  write request; held until acknowledged.
REQ-016 mem_ack  in  1  memory accepts the request in this cycle.
REQ-017 frame_done  out  1  one-cycle pulse when a whole frame has been committed.
REQ-018 overflow  out  1  sticky; a visible pixel was dropped.
REQ-019 busy  out  1  high while the FIFO is non-empty or mem_we is high.

Function
REQ-020 An input pixel SHALL be sampled on every rising edge where calculating=1.
REQ-021 A sampled pixel with x_draw<H_VISIBLE and y_draw<V_VISIBLE SHALL be pushed into the FIFO; other sampled pixels are discarded silently.
REQ-022 Each FIFO entry SHALL hold {address, intensity}, with address = y_draw*640 + x_draw computed in 19 bits without a multiplier (shift-add).
REQ-023 A push arriving while the FIFO is full and no pop happens in the same cycle SHALL be dropped and SHALL set overflow.
REQ-024 A push and a pop in the same cycle while full SHALL both succeed; the count stays unchanged and overflow is not set.
REQ-025 The FSM SHALL have the states IDLE and WRITE.
REQ-026 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into the mem_addr/mem_data registers and enter WRITE.
REQ-027 In WRITE, mem_we=1, and mem_addr and mem_data SHALL stay stable until a cycle with mem_ack=1.
REQ-028 On a WRITE cycle with mem_ack=1 and the FIFO non-empty, the next entry SHALL load and WRITE continues with no idle cycle (one write per clock maximum).
REQ-029 On a WRITE cycle with mem_ack=1 and the FIFO empty, the FSM SHALL return to IDLE and mem_we SHALL be 0 in the next cycle.
REQ-030 mem_ack SHALL be ignored while mem_we=0.
REQ-031 Latency: a visible pixel sampled at edge N, with the FIFO empty and the FSM in IDLE, SHALL appear with mem_we=1 after edge N+1.
REQ-032 Sampling x_draw=H_LAST and y_draw=V_LAST with calculating=1 SHALL set an internal frame-end flag.
REQ-033 frame_done SHALL pulse high for exactly one cycle in the first cycle where the frame-end flag is set, the FIFO is empty, and mem_we=0; the flag clears in that same cycle.
REQ-034 A new frame's pixels arriving before frame_done SHALL be buffered normally; frame_done SHALL still wait for the FIFO to empty.
REQ-035 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an occupancy count of log2(FIFO_DEPTH)+1 bits.
REQ-036 overflow SHALL remain at 1 until RESET.

Reset
REQ-037 While RESET=1: FSM=IDLE, FIFO emptied, frame-end flag cleared, mem_we=0, mem_addr=0, mem_data=0, frame_done=0, overflow=0, busy=0.
REQ-038 RESET asserted during WRITE SHALL abandon the pending write; mem_we=0 after that edge regardless of mem_ack.
REQ-039 Inputs sampled in a cycle where RESET=1 SHALL be ignored.

Verification
REQ-040 Pixel (x=5, y=2, intensity=0x80), mem_ack tied 1 -> mem_we=1, mem_addr=1285, mem_data=0x80 two edges later, for one cycle.
REQ-041 Pixels at (640,0), (0,480), and (799,524) -> no FIFO push and no mem_we; frame_done pulses once after the last pixel.
REQ-042 Ten consecutive visible pixels with mem_ack=0 -> first 8 buffered plus 1 held in the output registers; the 10th is dropped, overflow=1, and after ack all 9 are written in order.
REQ-043 mem_ack toggled 1-of-3 cycles during a full 800x525 scan -> exactly 307200 writes, addresses 0..307199 each once, then one frame_done.
REQ-044 RESET pulsed while mem_we=1 and the FIFO holds 4 entries -> mem_we=0 next cycle, busy=0, and no stale write appears after RESET is released.
REQ-045 Full FIFO with simultaneous push and ack -> no overflow, count stays 8, and data order is preserved.

Source files
------------

// File: rtl/pixel_writer.sv
// pixel_writer: buffers visible calculator pixels in a small FIFO and streams them to a
// frame-buffer write port using a held-request / ack handshake.
module pixel_writer #(
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned H_LAST     = 799,
   parameter int unsigned V_LAST     = 524,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        calculating,
   input  logic [9:0]  x_draw,
   input  logic [9:0]  y_draw,
   input  logic [7:0]  intensity,
   output logic [18:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic        frame_done,
   output logic        overflow,
   output logic        busy
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [9:0] HVis  = 10'(H_VISIBLE);
   localparam logic [9:0] VVis  = 10'(V_VISIBLE);
   localparam logic [9:0] HLast = 10'(H_LAST);
   localparam logic [9:0] VLast = 10'(V_LAST);
   localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

   typedef enum logic [0:0] {StIdle, StWrite} state_e;

   state_e          state_q, state_d;
   logic [26:0]     fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            frame_end_q;
   logic            overflow_q;
   logic [18:0]     addr_q;
   logic [7:0]      data_q;

   logic            visible, push, pop, accept;
   logic            fifo_empty, fifo_full, frame_end_hit;
   logic [18:0]     y_ext, pix_addr;
   logic [26:0]     head;

   // y*640 = y*512 + y*128
   assign y_ext      = {9'd0, y_draw};
   assign pix_addr   = (y_ext << 9) + (y_ext << 7) + {9'd0, x_draw};

   assign visible    = calculating && (x_draw < HVis) && (y_draw < VVis);
   assign push       = visible && !RESET;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CntFull);
   assign accept     = push && (!fifo_full || pop);
   assign head       = fifo_mem[rd_ptr_q];

   assign frame_end_hit = calculating && (x_draw == HLast) && (y_draw == VLast);

   assign mem_we     = (state_q == StWrite);
   assign mem_addr   = addr_q;
   assign mem_data   = data_q;
   assign overflow   = overflow_q;
   assign busy       = !RESET && (!fifo_empty || mem_we);
   assign frame_done = !RESET && frame_end_q && fifo_empty && (state_q == StIdle);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (mem_ack) begin
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         fifo_mem[wr_ptr_q] <= {pix_addr, intensity};
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_end_q <= 1'b0;
         overflow_q  <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         if (accept) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
            addr_q   <= head[26:8];
            data_q   <= head[7:0];
         end
         if (accept && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (!accept && pop) begin
            count_q <= count_q - CntW'(1);
         end
         if (push && !accept) begin
            overflow_q <= 1'b1;
         end
         // A new frame end sampled in the pulse cycle re-arms the flag.
         if (frame_end_hit) begin
            frame_end_q <= 1'b1;
         end else if (frame_done) begin
            frame_end_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: queue-based reference model compared every cycle,
// plus directed literal checks and a randomized phase.
module tb_pixel_writer;

   localparam int HV = 64, VV = 16, HL = 79, VL = 20, DEPTH = 8;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        calculating = 1'b0;
   logic [9:0]  x_draw = '0;
   logic [9:0]  y_draw = '0;
   logic [7:0]  intensity = '0;
   logic        mem_ack = 1'b0;
   logic [18:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_we, frame_done, overflow, busy;

   int checks = 0;
   int passes = 0;

   always #5 CLK = ~CLK;

   pixel_writer #(
      .H_VISIBLE (HV),
      .V_VISIBLE (VV),
      .H_LAST    (HL),
      .V_LAST    (VL),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .calculating(calculating),
      .x_draw     (x_draw),
      .y_draw     (y_draw),
      .intensity  (intensity),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_we     (mem_we),
      .mem_ack    (mem_ack),
      .frame_done (frame_done),
      .overflow   (overflow),
      .busy       (busy)
   );

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endfunction

   // Reference model: pending pixels as a queue plus the single entry being offered.
   typedef struct {int a; int d;} ent_t;
   ent_t fq[$];
   ent_t e;
   bit   hold_v = 0, m_ovf = 0, m_flag = 0, model_on = 0;
   int   hold_a = 0, hold_d = 0;
   bit   m_done, m_taken, m_pop, m_vis;
   int   sz0;

   int   wcount = 0, fd_count = 0;
   int   wlog[$];
   int   seen[int];

   always @(negedge CLK) begin
      if (model_on) begin
         chk("mem_we", int'(mem_we), int'(hold_v));
         chk("mem_addr", int'(mem_addr), hold_a);
         chk("mem_data", int'(mem_data), hold_d);
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("busy", int'(busy), int'(!RESET && (fq.size() != 0 || hold_v)));
         chk("frame_done", int'(frame_done),
             int'(!RESET && m_flag && fq.size() == 0 && !hold_v));
      end
      if (frame_done) fd_count++;
      if (mem_we && mem_ack && !RESET) begin
         wcount++;
         wlog.push_back(int'(mem_addr));
         if (seen.exists(int'(mem_addr))) seen[int'(mem_addr)]++;
         else seen[int'(mem_addr)] = 1;
      end
      // Advance the model to the state after the coming rising edge.
      if (RESET) begin
         fq.delete();
         hold_v = 0; hold_a = 0; hold_d = 0; m_ovf = 0; m_flag = 0;
      end else begin
         m_done  = m_flag && fq.size() == 0 && !hold_v;
         m_taken = hold_v && mem_ack;
         sz0     = fq.size();
         m_pop   = (sz0 > 0) && (!hold_v || m_taken);
         m_vis   = calculating && (int'(x_draw) < HV) && (int'(y_draw) < VV);
         if (m_pop) begin
            e = fq.pop_front();
            hold_a = e.a; hold_d = e.d; hold_v = 1;
         end else if (m_taken) begin
            hold_v = 0;
         end
         if (m_vis) begin
            if (sz0 < DEPTH || m_pop)
               fq.push_back('{a: int'(y_draw) * 640 + int'(x_draw), d: int'(intensity)});
            else
               m_ovf = 1;
         end
         if (calculating && int'(x_draw) == HL && int'(y_draw) == VL) m_flag = 1;
         else if (m_done) m_flag = 0;
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic pix(int x, int y, int v);
      calculating = 1'b1;
      x_draw = 10'(x);
      y_draw = 10'(y);
      intensity = 8'(v);
      cyc();
   endtask

   task automatic do_reset();
      calculating = 1'b0;
      RESET = 1'b1;
      cyc();
      RESET = 1'b0;
   endtask

   int fd0, t, ones;

   initial begin
      repeat (3) cyc();
      model_on = 1;
      RESET = 1'b0;
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);

      // Single pixel, ack tied high: offered two edges after sampling, for one cycle.
      mem_ack = 1'b1;
      pix(5, 2, 8'h80);
      calculating = 1'b0;
      cyc();
      chk("lat_mem_we", int'(mem_we), 1);
      chk("lat_mem_addr", int'(mem_addr), 1285);
      chk("lat_mem_data", int'(mem_data), 8'h80);
      cyc();
      chk("lat_we_drop", int'(mem_we), 0);

      // Invisible pixels and the frame-end pixel.
      repeat (3) cyc();
      pix(HV, 0, 1);
      pix(0, VV, 2);
      pix(640, 0, 3);
      chk("invis_busy", int'(busy), 0);
      fd0 = fd_count;
      pix(HL, VL, 4);
      calculating = 1'b0;
      chk("fd_pulse", int'(frame_done), 1);
      chk("fd_no_we", int'(mem_we), 0);
      cyc();
      chk("fd_single", int'(frame_done), 0);
      repeat (4) cyc();
      chk("fd_count", fd_count - fd0, 1);

      // Ten pixels without ack: nine held, tenth dropped.
      do_reset();
      mem_ack = 1'b0;
      for (int i = 0; i < 10; i++) pix(i, 1, i + 1);
      calculating = 1'b0;
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_busy", int'(busy), 1);
      wlog.delete();
      mem_ack = 1'b1;
      repeat (15) cyc();
      chk("ovf_nwrites", wlog.size(), 9);
      for (int k = 0; k < 9 && k < wlog.size(); k++) chk("ovf_order", wlog[k], 640 + k);
      chk("ovf_sticky", int'(overflow), 1);

      // Full FIFO with simultaneous push and ack.
      do_reset();
      mem_ack = 1'b0;
      for (int i = 0; i < 9; i++) pix(i, 3, 8'h40 + i);
      chk("full_no_ovf", int'(overflow), 0);
      wlog.delete();
      mem_ack = 1'b1;
      for (int i = 9; i < 13; i++) pix(i, 3, 8'h40 + i);
      calculating = 1'b0;
      chk("pp_no_ovf", int'(overflow), 0);
      repeat (15) cyc();
      chk("pp_nwrites", wlog.size(), 13);
      for (int k = 0; k < 13 && k < wlog.size(); k++) chk("pp_order", wlog[k], 3 * 640 + k);

      // Reset during a pending write.
      do_reset();
      mem_ack = 1'b0;
      for (int i = 0; i < 5; i++) pix(i, 5, i);
      calculating = 1'b0;
      chk("rw_we_before", int'(mem_we), 1);
      wlog.delete();
      mem_ack = 1'b1;
      RESET = 1'b1;
      cyc();
      RESET = 1'b0;
      chk("rw_we_after", int'(mem_we), 0);
      chk("rw_busy_after", int'(busy), 0);
      repeat (10) cyc();
      chk("rw_no_stale", wlog.size(), 0);

      // Randomized traffic.
      do_reset();
      repeat (3000) begin
         calculating = 1'($urandom_range(0, 1));
         x_draw = 10'($urandom_range(0, 90));
         y_draw = 10'($urandom_range(0, 22));
         if ($urandom_range(0, 99) == 0) begin
            x_draw = 10'(HL);
            y_draw = 10'(VL);
         end
         intensity = 8'($urandom_range(0, 255));
         mem_ack = ($urandom_range(0, 3) != 0);
         RESET = ($urandom_range(0, 499) == 0);
         cyc();
      end
      RESET = 1'b0;

      // Full scan, pixel sampled every 4th cycle, ack one cycle in three.
      do_reset();
      wcount = 0;
      seen.delete();
      fd0 = fd_count;
      t = 0;
      for (int y = 0; y <= VL; y++) begin
         for (int x = 0; x <= HL; x++) begin
            x_draw = 10'(x);
            y_draw = 10'(y);
            intensity = 8'(x + y);
            for (int k = 0; k < 4; k++) begin
               calculating = (k == 3);
               mem_ack = (t % 3 == 0);
               t++;
               cyc();
            end
         end
      end
      calculating = 1'b0;
      repeat (30) begin
         mem_ack = (t % 3 == 0);
         t++;
         cyc();
      end
      ones = 0;
      foreach (seen[a]) if (seen[a] == 1) ones++;
      chk("scan_writes", wcount, HV * VV);
      chk("scan_unique", ones, HV * VV);
      chk("scan_addrs", seen.num(), HV * VV);
      chk("scan_fd", fd_count - fd0, 1);
      chk("scan_no_ovf", int'(overflow), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
